// File: rtl/inst_fetch_mem_if.sv
// Fetch request/response, program-load write and fetch-count signals of the instruction memory.
interface inst_fetch_mem_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] address;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_inst;
  logic                  rsp_fault;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [15:0]           fetch_cnt;

  modport master (
    output req_valid, address, rsp_ready, wr_en, wr_addr, wr_data,
    input  req_ready, rsp_valid, rsp_inst, rsp_fault, fetch_cnt
  );

  modport slave (
    input  req_valid, address, rsp_ready, wr_en, wr_addr, wr_data,
    output req_ready, rsp_valid, rsp_inst, rsp_fault, fetch_cnt
  );
endinterface

// File: rtl/inst_fetch_mem.sv
// Instruction memory with a one-entry response register: fetch latency 1 cycle, read-before-write.
// Request side stalls only while an unconsumed response is held; program-load writes never stall.
module inst_fetch_mem #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 1024,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    BYTE_ADDR  = 0,
  parameter logic [DATA_WIDTH-1:0] FAULT_WORD = DATA_WIDTH'(32'h0F000000),
  parameter logic [DATA_WIDTH-1:0] FILL_WORD  = FAULT_WORD
) (
  input logic             clk,
  input logic             rst_n,
  inst_fetch_mem_if.slave bus
);
  localparam int                    OFF_BITS = (BYTE_ADDR != 0) ? $clog2(DATA_WIDTH / 8) : 0;
  localparam int                    IDX_W    = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((64'd1 << OFF_BITS) - 64'd1);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A  = ADDR_WIDTH'(DEPTH);

  // Range is checked on the full shifted address so high bits cannot alias into the array.
  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    return ((a >> OFF_BITS) < DEPTH_A) && ((a & OFF_MASK) == '0);
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] w;
    w = a >> OFF_BITS;
    return w[IDX_W-1:0];
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: FILL_WORD};
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_inst;
  logic                  rsp_fault;
  logic [15:0]           fetch_cnt;
  logic                  accept;
  logic                  fetch_ok;
  logic                  wr_ok;

  assign bus.req_ready = !rsp_valid || bus.rsp_ready;
  assign accept        = bus.req_valid && bus.req_ready;
  assign fetch_ok      = addr_ok(bus.address);
  assign wr_ok         = bus.wr_en && addr_ok(bus.wr_addr);

  // Contents are not reset, so a program survives reset; writes are ignored while held in reset.
  always_ff @(posedge clk) begin
    if (rst_n && wr_ok) begin
      mem[addr_idx(bus.wr_addr)] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_inst  <= '0;
      rsp_fault <= 1'b0;
      fetch_cnt <= '0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_inst  <= fetch_ok ? mem[addr_idx(bus.address)] : FAULT_WORD;
      rsp_fault <= !fetch_ok;
      fetch_cnt <= fetch_cnt + 16'd1;
    end else if (bus.rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_inst  = rsp_inst;
  assign bus.rsp_fault = rsp_fault;
  assign bus.fetch_cnt = fetch_cnt;
endmodule

// File: tb/tb_inst_fetch_mem.sv
// Directed bench: word-addressed instance (DEPTH 1024) plus byte-addressed instance (DEPTH 16).
module tb_inst_fetch_mem;
  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  inst_fetch_mem_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) a ();
  inst_fetch_mem_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) b ();

  inst_fetch_mem #(.DATA_WIDTH(32), .DEPTH(1024), .ADDR_WIDTH(32), .BYTE_ADDR(0)) u_word (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a)
  );

  inst_fetch_mem #(.DATA_WIDTH(32), .DEPTH(16), .ADDR_WIDTH(32), .BYTE_ADDR(1)) u_byte (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_a(input logic [31:0] addr, input logic [31:0] data);
    a.wr_en   = 1'b1;
    a.wr_addr = addr;
    a.wr_data = data;
    tick();
    a.wr_en   = 1'b0;
  endtask

  task automatic wr_b(input logic [31:0] addr, input logic [31:0] data);
    b.wr_en   = 1'b1;
    b.wr_addr = addr;
    b.wr_data = data;
    tick();
    b.wr_en   = 1'b0;
  endtask

  // One accepted fetch on the byte instance, then let the response drain.
  task automatic fetch_b(input string tag, input logic [31:0] addr,
                         input logic [31:0] exp_inst, input logic exp_fault);
    b.req_valid = 1'b1;
    b.address   = addr;
    tick();
    b.req_valid = 1'b0;
    chk({tag, "_valid"}, b.rsp_valid, 1);
    chk({tag, "_inst"}, b.rsp_inst, exp_inst);
    chk({tag, "_fault"}, b.rsp_fault, exp_fault);
    tick();
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    a.req_valid = 1'b0; a.address = '0; a.rsp_ready = 1'b1;
    a.wr_en     = 1'b0; a.wr_addr = '0; a.wr_data   = '0;
    b.req_valid = 1'b0; b.address = '0; b.rsp_ready = 1'b1;
    b.wr_en     = 1'b0; b.wr_addr = '0; b.wr_data   = '0;

    #1;
    chk("rst_valid", a.rsp_valid, 0);
    chk("rst_inst", a.rsp_inst, 0);
    chk("rst_fault", a.rsp_fault, 0);
    chk("rst_cnt", a.fetch_cnt, 0);
    chk("rst_ready", a.req_ready, 1);
    #20 rst_n = 1'b1;
    tick();
    chk("post_rst_ready", a.req_ready, 1);

    wr_a(32'd1, 32'h02010001);
    wr_a(32'd0, 32'h11110000);
    wr_a(32'd2, 32'h22220002);
    wr_a(32'd3, 32'h33330003);
    wr_a(32'd5, 32'h0A0A0003);

    // Single fetch, latency one edge
    a.req_valid = 1'b1; a.address = 32'd1;
    tick();
    a.req_valid = 1'b0;
    chk("f1_valid", a.rsp_valid, 1);
    chk("f1_inst", a.rsp_inst, 32'h02010001);
    chk("f1_fault", a.rsp_fault, 0);
    chk("f1_cnt", a.fetch_cnt, 1);
    tick();
    chk("f1_drain", a.rsp_valid, 0);

    // Back-to-back 0,1,2
    a.req_valid = 1'b1; a.address = 32'd0;
    #1 chk("b2b_rdy0", a.req_ready, 1);
    tick();
    chk("b2b_inst0", a.rsp_inst, 32'h11110000);
    a.address = 32'd1;
    #1 chk("b2b_rdy1", a.req_ready, 1);
    tick();
    chk("b2b_inst1", a.rsp_inst, 32'h02010001);
    a.address = 32'd2;
    #1 chk("b2b_rdy2", a.req_ready, 1);
    tick();
    chk("b2b_inst2", a.rsp_inst, 32'h22220002);
    chk("b2b_valid2", a.rsp_valid, 1);
    chk("b2b_cnt", a.fetch_cnt, 4);
    a.req_valid = 1'b0;
    tick();
    chk("b2b_drain", a.rsp_valid, 0);

    // Backpressure: word 3 held for four cycles while word 2 waits
    a.req_valid = 1'b1; a.address = 32'd3; a.rsp_ready = 1'b0;
    tick();
    a.address = 32'd2;
    for (int i = 0; i < 4; i++) begin
      #1 chk("bp_ready", a.req_ready, 0);
      tick();
      chk("bp_valid", a.rsp_valid, 1);
      chk("bp_inst", a.rsp_inst, 32'h33330003);
    end
    chk("bp_cnt", a.fetch_cnt, 5);
    a.rsp_ready = 1'b1;
    #1 chk("bp_release_ready", a.req_ready, 1);
    tick();
    chk("bp_next_inst", a.rsp_inst, 32'h22220002);
    chk("bp_next_cnt", a.fetch_cnt, 6);
    a.req_valid = 1'b0;
    tick();

    // Range faults, last valid word, dropped out-of-range write
    a.req_valid = 1'b1; a.address = 32'd1024;
    tick();
    chk("oor_fault", a.rsp_fault, 1);
    chk("oor_inst", a.rsp_inst, 32'h0F000000);
    a.address = 32'd1023;
    tick();
    chk("last_fault", a.rsp_fault, 0);
    chk("last_inst", a.rsp_inst, 32'h0F000000);
    chk("fault_cnt", a.fetch_cnt, 8);
    a.req_valid = 1'b0;
    tick();
    wr_a(32'd1025, 32'hDEADBEEF);
    a.req_valid = 1'b1; a.address = 32'd1;
    tick();
    a.req_valid = 1'b0;
    chk("oor_wr_dropped", a.rsp_inst, 32'h02010001);
    tick();

    // Byte-addressed instance
    fetch_b("b_mis6", 32'd6, 32'h0F000000, 1'b1);
    wr_b(32'd4, 32'hCAFE0001);
    wr_b(32'd5, 32'h12345678);
    fetch_b("b_al4", 32'd4, 32'hCAFE0001, 1'b0);
    fetch_b("b_fill8", 32'd8, 32'h0F000000, 1'b0);
    fetch_b("b_oor64", 32'd64, 32'h0F000000, 1'b1);
    fetch_b("b_last60", 32'd60, 32'h0F000000, 1'b0);
    chk("b_cnt", b.fetch_cnt, 5);

    // Same-edge write and fetch: old word first
    a.wr_en = 1'b1; a.wr_addr = 32'd5; a.wr_data = 32'hAAAA5555;
    a.req_valid = 1'b1; a.address = 32'd5;
    tick();
    a.wr_en = 1'b0;
    chk("rbw_old", a.rsp_inst, 32'h0A0A0003);
    tick();
    chk("rbw_new", a.rsp_inst, 32'hAAAA5555);
    chk("rbw_cnt", a.fetch_cnt, 11);

    // Counter wrap under continuous fetches
    a.address = 32'd0;
    repeat (65535 - 11) tick();
    chk("cnt_ffff", a.fetch_cnt, 32'h0000FFFF);
    tick();
    chk("cnt_wrap", a.fetch_cnt, 0);
    a.req_valid = 1'b0;
    tick();

    // Asynchronous reset with a held response
    a.req_valid = 1'b1; a.address = 32'd1; a.rsp_ready = 1'b0;
    tick();
    chk("pre_rst_valid", a.rsp_valid, 1);
    chk("pre_rst_cnt", a.fetch_cnt, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", a.rsp_valid, 0);
    chk("arst_inst", a.rsp_inst, 0);
    chk("arst_fault", a.rsp_fault, 0);
    chk("arst_cnt", a.fetch_cnt, 0);
    chk("arst_ready", a.req_ready, 1);
    a.wr_en = 1'b1; a.wr_addr = 32'd1; a.wr_data = 32'h55555555;
    tick();
    tick();
    a.wr_en = 1'b0; a.req_valid = 1'b0; a.rsp_ready = 1'b1;
    rst_n = 1'b1;
    tick();
    chk("post_arst_valid", a.rsp_valid, 0);
    a.req_valid = 1'b1; a.address = 32'd1;
    tick();
    a.req_valid = 1'b0;
    chk("survive_inst", a.rsp_inst, 32'h02010001);
    chk("survive_cnt", a.fetch_cnt, 1);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
